// File: rtl/manchester_pkg.sv
// manchester_pkg: shared FSM states, line polarity and sizing helper for the Manchester link
package manchester_pkg;
  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;
  localparam logic MAN_ONE_FIRST_HALF = 1'b1;
  localparam logic MAN_ZERO_FIRST_HALF = 1'b0;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/manchester_bit_timer.sv
// manchester_bit_timer: half-bit counter and phase flag producing half/bit ticks
module manchester_bit_timer #(
  parameter int HALF_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic half_tick_o,
  output logic bit_tick_o,
  output logic phase_o
);
  localparam int HB_W = HALF_BIT > 1 ? $clog2(HALF_BIT) : 1;
  localparam logic [HB_W-1:0] HB_MAX = HB_W'(HALF_BIT - 1);
  logic [HB_W-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d;
  // tick decode and next counter/phase; the counter wraps at HALF_BIT-1
  always_comb begin
    half_tick_o = cnt_q == HB_MAX;
    bit_tick_o = half_tick_o && phase_q;
    phase_o = phase_q;
    cnt_d = clr_i ? '0 : !en_i ? cnt_q : half_tick_o ? '0 : cnt_q + 1'b1;
    phase_d = clr_i ? 1'b0 : phase_q ^ (en_i && half_tick_o);
  end
  // counter and phase registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/manchester_tx.sv
// manchester_tx: frames a parallel word as preamble + LSB-first Manchester data + low guard gap
module manchester_tx
  import manchester_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int HALF_BIT = 4,
  parameter int PRE_LEN  = 4,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
  localparam int BC_W = $clog2(max3(PRE_LEN, DATA_W, GAP_BITS) + 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic tx_q, tx_d, clr, half_tick, bit_tick, phase, phase_n, last, first_half;
  manchester_bit_timer #(.HALF_BIT(HALF_BIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr_i(clr),
    .en_i(busy),
    .half_tick_o(half_tick),
    .bit_tick_o(bit_tick),
    .phase_o(phase)
  );
  // status outputs decode straight from the state register so reset clears them at once
  always_comb begin
    in_ready = state_q == IDLE;
    busy = !in_ready;
    last = state_q == PRE  ? bit_cnt_q == BC_W'(PRE_LEN - 1) :
           state_q == DATA ? bit_cnt_q == BC_W'(DATA_W - 1) :
                             bit_cnt_q == BC_W'(GAP_BITS - 1);
    done = state_q == GAP && bit_tick && last;
    tx_out = tx_q;
  end
  // next state, shift register and bit counter; tx is precomputed from next-cycle bit and phase
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_cnt_d = bit_cnt_q;
    clr = 1'b0;
    if (busy && bit_tick) bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (in_valid) begin
        shreg_d = in_data;
        bit_cnt_d = '0;
        clr = 1'b1;
        state_d = PRE;
      end
      PRE:  if (bit_tick && last) state_d = DATA;
      DATA: if (bit_tick) begin
        shreg_d = shreg_q >> 1;
        state_d = last ? GAP : DATA;
      end
      GAP:  if (bit_tick && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    phase_n = clr ? 1'b0 : phase ^ (busy && half_tick);
    first_half = (state_d == PRE || shreg_d[0]) ? MAN_ONE_FIRST_HALF : MAN_ZERO_FIRST_HALF;
    tx_d = (state_d == PRE || state_d == DATA) && (first_half ^ phase_n);
  end
  // state, data and line registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      tx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: doc/manchester_tx.md
# manchester_tx

Manchester-encoding serial transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single line. Each frame is a preamble of encoded `1` bits, then the data bits LSB-first, then a low guard gap. It is the transmit end of the team's Manchester link and generates exactly the line format our Manchester receiver decodes: mid-bit rising edge = `0`, mid-bit falling edge = `1`.

## Interface
- `DATA_W`, 16, payload bits per frame; must be ≥ 2.
- `HALF_BIT`, 4, clocks per half-bit; must be ≥ 1.
- `PRE_LEN`, 4, preamble length in bits (all encoded `1`); must be ≥ 1.
- `GAP_BITS`, 2, guard gap in bit periods (line low) after the last data bit; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_data`  in  DATA_W  word to transmit.
- `in_valid`  in  1  `in_data` is offered.
- `in_ready`  out  1  block can accept a word; high only in IDLE.
- `tx_out`  out  1  Manchester line, registered.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on the last cycle of the gap.

## Operation
- States: IDLE, PRE, DATA, GAP. The encoding constants are in the package.
- **IDLE:** `tx_out`=0 and `in_ready`=1. When `in_valid && in_ready` is sampled:
  - latch `in_data` into the shift register;
  - clear the half-bit counter, the phase flag and the bit counter;
  - go to PRE.
- **Bit encoding:**
  - Bit `1`: first half high, second half low.
  - Bit `0`: first half low, second half high.
  - `tx_out` is registered from the current bit and phase.
- **PRE:** send `PRE_LEN` `1` bits, then go to DATA.
- **DATA:** send `shreg[0]` and shift right after each full bit. Go to GAP after `DATA_W` bits.
- **GAP:** `tx_out`=0 for `GAP_BITS*2*HALF_BIT` clocks. `done`=1 on the final gap cycle, then return to IDLE.
- **Counters:**
  - half-bit counter is `$clog2(HALF_BIT)` bits wide (min 1) and wraps at `HALF_BIT-1`;
  - bit counter is `$clog2(max(PRE_LEN, DATA_W, GAP_BITS)+1)` bits wide;
  - no counter ever reaches an unused wrap value.
- **Handshake:** `in_valid` outside IDLE is ignored. No word is queued or dropped silently, because `in_ready` is already low. `in_data` is sampled only at acceptance; later changes have no effect.
- **Reset values:**
  - `tx_out`=0, `busy`=0, `done`=0, `in_ready`=1;
  - state = IDLE, all counters 0, shift register 0.
- **Reset mid-frame:** outputs take their reset values immediately (asynchronous). The partial frame is abandoned and the next accepted word restarts from the preamble.
- **Back-to-back words:** `in_valid` held high with new data is accepted on the first IDLE cycle after `done`. Adjacent frames are therefore separated by exactly the gap plus one IDLE cycle.

## Timing
- Cycle k is the cycle after the k-th rising edge following the acceptance edge.
- Frame length `F` = `(PRE_LEN+DATA_W)*2*HALF_BIT` cycles; `tx_out` carries the encoded frame during cycles 1..F.
- Cycles F+1..F+`GAP_BITS*2*HALF_BIT` are the gap, with `done` high in the last of them.
- `in_ready` rises in the cycle after `done`.
- `busy` rises in cycle 1 and falls together with `in_ready`.
- Every mid-bit transition occurs exactly `HALF_BIT` cycles after the bit start. Boundary transitions occur only between equal adjacent bits.

## Structure
- Package `manchester_pkg` holds:
  - the state typedef/localparams (IDLE, PRE, DATA, GAP);
  - the polarity constants `MAN_ONE_FIRST_HALF`=1 and `MAN_ZERO_FIRST_HALF`=0, shared with the receiver.
- Sub-module `manchester_bit_timer`: half-bit counter plus phase flag. It emits `half_tick` and `bit_tick` and has a synchronous clear at acceptance.
- The top level holds the FSM, shift register, bit counter and output registers.

## Test plan
All scenarios use default parameters (`F`=160, gap 16).
- **Reset:** hold `rst`=0 for 3 cycles. Required: `tx_out`=0, `in_ready`=1, `busy`=0, `done`=0.
- **Single word:** send `16'h00A5`.
  - Cycles 1..32 must be the pattern H4L4 repeated four times (preamble).
  - Data bits are LSB-first `1,0,1,0,0,1,0,1` then eight `0`s; cycles 33..40 are H4L4 and cycles 41..48 are L4H4.
  - `done` is high at cycle 176 and `in_ready` rises at cycle 177.
- **Busy ignore:** toggle `in_valid` with `16'hFFFF` during cycles 10..150 of a `16'h0000` frame. Required: the line stays the `16'h0000` encoding, and exactly one `done` pulse occurs.
- **Back-to-back:** hold `in_valid`=1 and send `16'h1234` then `16'hFFFF`. Required: the second preamble starts at cycle 178 after the first acceptance, and both decode correctly through the receiver loopback.
- **Reset mid-frame:** pull `rst` low at cycle 70. Required: `tx_out`=0 immediately. After release, a new word `16'h8001` produces a complete, correct frame.
- **Parameter corner:** `HALF_BIT`=1, `DATA_W`=2, `PRE_LEN`=1, word `2'b10`. Required line: H L, L H, H L, then 4 low cycles with `done` on the 4th.
